pc_seq: RTL
===========

# pc_seq

Fetch-stage sequencer that owns the program counter and decides each cycle whether it advances by 2, holds, or loads a redirect target. It arbitrates among exception entry (SIIC), return-from-exception (RTI), execute-stage branch/jump redirects, halt and hazard stalls. It also handshakes with instruction memory and drains a stale fetch after a redirect. It sits between the hazard/execute logic and the instruction memory port, and replaces ad-hoc PC select muxing.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- EXC_VECTOR, 16'h0002, PC loaded on SIIC entry
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- imem_ready  in  1  instruction memory has returned data for the outstanding fetch
- stall  in  1  hazard unit: hold PC, no new fetch accepted
- redir_valid  in  1  execute-stage branch taken or jump
- redir_target  in  16  redirect target (already computed: PC+2+imm or Rs+imm)
- siic  in  1  illegal instruction detected in execute
- siic_pc  in  16  PC+2 of the faulting instruction
- rti  in  1  return-from-exception in execute
- halt  in  1  HALT instruction retired
- pc  out  16  current fetch address (registered)
- fetch_req  out  1  fetch request to instruction memory
- fetch_valid  out  1  instruction at pc accepted this cycle; IF/ID may load
- flush  out  1  squash younger instructions (IF/ID, ID/EX) this cycle
- epc  out  16  saved exception return address (registered)
- in_exc  out  1  executing the exception handler
- halted  out  1  sequencer in HALT
- err  out  1  sticky: SIIC received while in_exc

## Operation
- States: RUN, DRAIN, HALT. Reset state RUN.
- Event priority, highest first: siic, rti, redir_valid, halt, stall, sequential. At most one event is acted on per cycle.
- siic, with in_exc=0: epc<=siic_pc, pc<=EXC_VECTOR, in_exc<=1, flush=1.
- siic, with in_exc=1: err<=1, go HALT, flush=1; epc is unchanged.
- rti: pc<=epc, in_exc<=0, flush=1. An rti with in_exc=0 still loads epc.
- redir_valid: pc<=redir_target, flush=1.
- After any redirect (siic/rti/redir): if imem_ready=0 in that cycle, go DRAIN, otherwise stay RUN.
- halt: go HALT and hold pc. flush=0.
- stall in RUN: hold pc, fetch_valid=0.
- Sequential: in RUN with imem_ready=1 and no higher event, fetch_valid=1 and pc<=pc+2, with 16-bit wrap (16'hFFFE -> 16'h0000).
- RUN with imem_ready=0 and no event: hold pc, fetch_valid=0, fetch_req stays 1.
- DRAIN: fetch_req=0 and fetch_valid=0. Wait for imem_ready=1, discard that response, then return to RUN.
  - siic, rti or redir_valid in DRAIN: load the new target and stay in DRAIN.
  - halt in DRAIN: go to HALT immediately.
- HALT: fetch_req=0, fetch_valid=0 and pc frozen. All inputs are ignored. Only rst exits.
- fetch_req=1 in RUN only.

## Timing
- Reset values (asynchronous, while rst=0):
  - pc=RESET_PC, epc=0
  - in_exc=0, err=0, halted=0
  - fetch_req=0, fetch_valid=0, flush=0
- First cycle after rst deasserts: fetch_req=1 at pc=RESET_PC.
- pc, epc, in_exc, err and state are registered; the new value is visible the cycle after the event.
- fetch_valid and flush are combinational from state and the current inputs. They are valid in the same cycle as the event.
- halted=1 from the cycle after halt is sampled.
- Redirect latency: target appears on pc 1 cycle after redir_valid. The first valid fetch from the target comes no earlier than that cycle, or after DRAIN completes.
- Reset asserted mid-DRAIN or mid-HALT: returns to RUN at RESET_PC with no residual state.
- Simultaneous events:
  - siic and redir_valid in the same cycle: siic wins and the redirect is dropped.
  - halt and stall: HALT.
  - redir_valid and stall: the redirect is taken.

## Test plan
- Sequential fetch: reset, then hold imem_ready=1 for 4 cycles -> pc goes 0,2,4,6,8; fetch_valid=1 each cycle; flush=0.
- Branch with an outstanding fetch:
  - At pc=6 with imem_ready=0, pulse redir_valid with target 16'h0040 -> flush=1; state DRAIN; pc=0x40 next cycle.
  - Then imem_ready=1 -> response discarded (fetch_valid=0); next cycle RUN fetches 0x40.
- Exception round trip:
  - siic with siic_pc=0x0012 -> pc=0x0002, epc=0x0012, in_exc=1.
  - Later rti -> pc=0x0012, in_exc=0.
- Nested SIIC: siic again while in_exc=1 -> err=1, halted=1; epc stays 0x0012; pc frozen while imem_ready toggles.
- Priority and stall:
  - siic and redir_valid (target 0x80) in the same cycle -> pc=EXC_VECTOR.
  - stall=1 for 3 cycles -> pc unchanged, fetch_valid=0.
  - stall with redir_valid -> pc=target.
- Wrap and reset: run from pc=0xFFFE -> next pc=0x0000. Then assert rst in HALT -> pc=RESET_PC and all flags 0.

Source files
------------

// File: rtl/pc_seq.sv
// ============================================================================
// pc_seq : fetch-stage PC sequencer (sequential / redirect / drain / halt)
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_seq #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [15:0] redir_target,
  input  logic        siic,
  input  logic [15:0] siic_pc,
  input  logic        rti,
  input  logic        halt,
  output logic [15:0] pc,
  output logic        fetch_req,
  output logic        fetch_valid,
  output logic        flush,
  output logic [15:0] epc,
  output logic        in_exc,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] epc_q, epc_d;
  logic        in_exc_q, in_exc_d;
  logic        err_q, err_d;
  logic        valid_now;
  logic        flush_now;
  logic        redirect;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    in_exc_d  = in_exc_q;
    err_d     = err_q;
    valid_now = 1'b0;
    flush_now = 1'b0;
    redirect  = 1'b0;

    case (state_q)
      ST_RUN, ST_DRAIN: begin
        if (siic) begin
          flush_now = 1'b1;
          if (in_exc_q) begin
            // A fault inside the handler is unrecoverable: park the core.
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            epc_d    = siic_pc;
            pc_d     = EXC_VECTOR;
            in_exc_d = 1'b1;
            redirect = 1'b1;
          end
        end else if (rti) begin
          flush_now = 1'b1;
          pc_d      = epc_q;
          in_exc_d  = 1'b0;
          redirect  = 1'b1;
        end else if (redir_valid) begin
          flush_now = 1'b1;
          pc_d      = redir_target;
          redirect  = 1'b1;
        end else if (halt) begin
          state_d = ST_HALT;
        end else if (state_q == ST_DRAIN) begin
          if (imem_ready) begin
            state_d = ST_RUN;
          end
        end else if (!stall && imem_ready) begin
          valid_now = 1'b1;
          pc_d      = pc_q + 16'd2;
        end

        // The fetch in flight belongs to the old path; drain it unless it
        // completes in this very cycle.
        if (redirect) begin
          state_d = ((state_q == ST_DRAIN) || !imem_ready) ? ST_DRAIN : ST_RUN;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      epc_q    <= 16'h0000;
      in_exc_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      in_exc_q <= in_exc_d;
      err_q    <= err_d;
    end
  end

  // Gated by rst so every handshake output reads 0 while reset is held.
  assign fetch_req   = rst & (state_q == ST_RUN);
  assign fetch_valid = rst & valid_now;
  assign flush       = rst & flush_now;
  assign halted      = (state_q == ST_HALT);
  assign pc          = pc_q;
  assign epc         = epc_q;
  assign in_exc      = in_exc_q;
  assign err         = err_q;

endmodule

`default_nettype wire
